// File: rtl/rr_sched_8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin grant scheduler.
package rr_sched_8_pkg;

    // Default index width and the matching number of request lines.
    localparam int unsigned WidthI         = 3;
    localparam int unsigned NumReq         = 1 << WidthI;
    // Default maximum grant length in cycles before a forced release.
    localparam int unsigned HoldMaxDefault = 16;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

endpackage

// File: rtl/rr_sched_8_pick.sv
// Wrap-around priority search: first set request at or above ptr, wrapping N-1 -> 0.
module rr_pick
    import rr_sched_8_pkg::*;
#(
    parameter int unsigned WIDTHI = WidthI
) (
    input  logic [2**WIDTHI-1:0] req,
    input  logic [WIDTHI-1:0]    ptr,
    output logic [WIDTHI-1:0]    winner,
    output logic                 any
);

    localparam int N = 2**WIDTHI;

    logic [WIDTHI-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + WIDTHI'(i);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_sched_8.sv
// Round-robin grant scheduler with a bounded grant length and registered decoder outputs.
module rr_sched_8
    import rr_sched_8_pkg::*;
#(
    parameter int unsigned WIDTHI   = WidthI,
    parameter int unsigned HOLD_MAX = HoldMaxDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2**WIDTHI-1:0] req,
    input  logic                 done,
    output logic [WIDTHI-1:0]    idx,
    output logic                 en_n,
    output logic                 busy,
    output logic                 timeout
);

    // Counter only needs to reach HOLD_MAX-1.
    localparam int unsigned HoldW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_MAX - 1);

    state_e            state_q, state_d;
    logic [WIDTHI-1:0] ptr_q, ptr_d;
    logic [WIDTHI-1:0] idx_q, idx_d;
    logic              en_n_q, en_n_d;
    logic              timeout_q, timeout_d;
    logic [HoldW-1:0]  hold_q, hold_d;

    logic [WIDTHI-1:0] winner;
    logic              any;

    rr_pick #(
        .WIDTHI (WIDTHI)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    // Next-state: arbitrate in idle, hold or release the grant otherwise.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        en_n_d    = en_n_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                en_n_d = 1'b1;
                if (any) begin
                    idx_d   = winner;
                    en_n_d  = 1'b0;
                    ptr_d   = winner + WIDTHI'(1);
                    hold_d  = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                en_n_d = 1'b0;
                if (hold_q != HoldLast) begin
                    hold_d = hold_q + HoldW'(1);
                end
                // done beats the timeout so a finishing consumer never sees a pulse.
                if (done || !req[idx_q]) begin
                    en_n_d  = 1'b1;
                    state_d = StIdle;
                end else if (hold_q == HoldLast) begin
                    en_n_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                en_n_d  = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            idx_q     <= '0;
            en_n_q    <= 1'b1;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            en_n_q    <= en_n_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    assign idx     = idx_q;
    assign en_n    = en_n_q;
    assign busy    = ~en_n_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_sched_8.sv
// Self-checking bench for rr_sched_8: directed scenarios plus a randomized run vs a reference model.
module tb_rr_sched_8;

    localparam int NREQ = 8;
    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [2:0] idx;
    logic       en_n;
    logic       busy;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (plain integers, cycle-level behaviour).
    int  m_ptr = 0;
    int  m_idx = 0;
    bit  m_grant = 0;
    int  m_held = 0;
    bit  m_to = 0;

    rr_sched_8 #(
        .WIDTHI   (3),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .idx     (idx),
        .en_n    (en_n),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step(input logic r, input logic [7:0] q, input logic d);
        int w;
        if (r) begin
            m_grant = 0; m_ptr = 0; m_idx = 0; m_held = 0; m_to = 0;
        end else if (!m_grant) begin
            m_to = 0;
            w = pick(q, m_ptr);
            if (w >= 0) begin
                m_idx = w; m_ptr = (w + 1) % NREQ; m_grant = 1; m_held = 1;
            end
        end else begin
            m_to = 0;
            if (d || !q[m_idx]) begin
                m_grant = 0;
            end else if (m_held == HOLD) begin
                m_grant = 0; m_to = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic tick(input logic r, input logic [7:0] q, input logic d);
        rst = r; req = q; done = d;
        @(posedge clk);
        model_step(r, q, d);
        #1;
        chk("model_idx", 32'(idx), 32'(m_idx));
        chk("model_en_n", 32'(en_n), 32'(!m_grant));
        chk("model_busy", 32'(busy), 32'(m_grant));
        chk("model_timeout", 32'(timeout), 32'(m_to));
    endtask

    initial begin
        int lows;
        int tos;

        // Reset with all requests asserted.
        tick(1, 8'hFF, 0);
        tick(1, 8'hFF, 0);
        chk("reset_en_n", 32'(en_n), 32'd1);
        chk("reset_idx", 32'(idx), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);

        // Single request, then done.
        tick(0, 8'h20, 0);
        chk("single_idx", 32'(idx), 32'd5);
        chk("single_en_n", 32'(en_n), 32'd0);
        tick(0, 8'h20, 1);
        chk("single_release", 32'(en_n), 32'd1);
        tick(0, 8'h00, 1);
        chk("done_in_idle", 32'(en_n), 32'd1);

        // Wrap from ptr=6.
        tick(0, 8'h05, 0);
        chk("wrap_first", 32'(idx), 32'd0);
        tick(0, 8'h05, 1);
        tick(0, 8'h05, 0);
        chk("wrap_second", 32'(idx), 32'd2);
        tick(0, 8'h05, 1);

        // Rotation from ptr=0 with all requesting.
        tick(1, 8'h00, 0);
        for (int g = 0; g <= NREQ; g++) begin
            tick(0, 8'hFF, 0);
            chk("rot_idx", 32'(idx), 32'(g % NREQ));
            chk("rot_en_n", 32'(en_n), 32'd0);
            tick(0, 8'hFF, 1);
            chk("rot_gap", 32'(en_n), 32'd1);
        end

        // Forced release after HOLD cycles.
        tick(1, 8'h00, 0);
        lows = 0;
        tos = 0;
        for (int c = 0; c < HOLD + 1; c++) begin
            tick(0, 8'h02, 0);
            if (en_n == 1'b0) lows++;
            if (timeout) tos++;
        end
        chk("to_low_cycles", 32'(lows), 32'(HOLD));
        chk("to_pulse_count", 32'(tos), 32'd1);
        chk("to_pulse_now", 32'(timeout), 32'd1);
        chk("to_release", 32'(en_n), 32'd1);

        // Regrant, then done exactly on the timeout cycle.
        tick(0, 8'h02, 0);
        chk("to_pulse_one_cycle", 32'(timeout), 32'd0);
        chk("regrant_idx", 32'(idx), 32'd1);
        for (int c = 0; c < HOLD - 1; c++) tick(0, 8'h02, 0);
        tick(0, 8'h02, 1);
        chk("done_beats_timeout", 32'(timeout), 32'd0);
        chk("done_beats_en_n", 32'(en_n), 32'd1);

        // Reset in the middle of a grant.
        tick(0, 8'h08, 0);
        chk("mid_grant_idx", 32'(idx), 32'd3);
        tick(0, 8'h08, 0);
        tick(1, 8'h08, 0);
        chk("mid_rst_en_n", 32'(en_n), 32'd1);
        chk("mid_rst_idx", 32'(idx), 32'd0);
        chk("mid_rst_timeout", 32'(timeout), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] q;
            logic       r;
            logic       d;
            q = 8'($urandom);
            if ($urandom_range(0, 3) == 0) q = q & 8'($urandom);
            if ($urandom_range(0, 7) == 0) q = 8'h00;
            r = ($urandom_range(0, 99) == 0);
            d = ($urandom_range(0, 9) == 0);
            tick(r, q, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_sched_8.md
RR_SCHED_8 -- requirements
Module: rr_sched_8

Interface
REQ-001 The block SHALL have parameter WIDTHI, default 3, meaning index width; N = 2**WIDTHI request lines (8).
REQ-002 The block SHALL have parameter HOLD_MAX, default 16, meaning the maximum number of cycles a grant stays active before forced release.
REQ-003 The block SHALL have a single clock, clk, and a synchronous, active-high reset, rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N  request lines, one per client, level-sensitive.
REQ-007 done  input  1  consumer pulse: current grant finished.
REQ-008 idx  output  WIDTHI  registered index of the granted client; drives the downstream decoder select.
REQ-009 en_n  output  1  registered active-low enable for the downstream decoder; 0 = grant active.
REQ-010 busy  output  1  high while a grant is active (equals ~en_n).
REQ-011 timeout  output  1  one-cycle pulse when a grant is force-released.

Function
REQ-012 The block SHALL implement two states: IDLE and GRANT.
REQ-013 In IDLE with req == 0, the block SHALL hold en_n=1 and keep idx unchanged.
REQ-014 In IDLE with req != 0, the block SHALL select the winner as the first set bit of req, searching upward from pointer ptr and wrapping N-1 -> 0.
REQ-015 On that IDLE edge, the block SHALL register idx<=winner, en_n<=0, ptr<=(winner+1) mod N, clear the hold counter, and enter GRANT; grant latency is 1 cycle after req is sampled.
REQ-016 In GRANT, idx SHALL remain stable and en_n SHALL remain 0.
REQ-017 In GRANT, the hold counter SHALL increment by 1 every cycle, saturating at HOLD_MAX-1.
REQ-018 In GRANT, done=1 or req[idx]=0 SHALL cause en_n<=1 and a return to IDLE on the next edge.
REQ-019 In GRANT, a hold counter of HOLD_MAX-1 with done=0 and req[idx]=1 SHALL cause en_n<=1, timeout<=1 for one cycle, and a return to IDLE.
REQ-020 If done and the timeout condition occur in the same cycle, done SHALL win and timeout SHALL stay 0.
REQ-021 done while in IDLE SHALL be ignored.
REQ-022 After any release, the block SHALL spend at least one cycle in IDLE with en_n=1, so grants are separated by at least one idle cycle.
REQ-023 Requests changing in GRANT, other than req[idx], SHALL have no effect until IDLE.
REQ-024 Fairness: a client continuously requesting SHALL be granted within N grants.
REQ-025 ptr arithmetic SHALL be WIDTHI-bit modulo N; winner+1 at N-1 SHALL wrap to 0.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, idx=0, en_n=1, busy=0, timeout=0, and hold counter=0.
REQ-027 rst asserted mid-GRANT SHALL abort the grant (en_n=1 next cycle) without asserting timeout.
REQ-028 rst SHALL take priority over all other inputs.

Structure
REQ-029 A shared package SHALL hold WIDTHI, N, the HOLD_MAX default, and the IDLE/GRANT state encoding.
REQ-030 The wrap-around priority search SHALL be a combinational sub-module, rr_pick (inputs req, ptr; outputs winner, any).
REQ-031 All outputs SHALL be registered; no combinational path SHALL exist from req/done to idx/en_n.

Verification
REQ-032 The bench SHALL check reset: rst=1 for 2 cycles with req=8'hFF, then expect en_n=1, idx=0, busy=0, timeout=0.
REQ-033 The bench SHALL check single request: req=8'h20 in IDLE -> next cycle idx=5, en_n=0; done pulse -> en_n=1 the following cycle, ptr=6.
REQ-034 The bench SHALL check rotation: req=8'hFF held with done pulsed each grant -> idx sequence 0,1,2,...,7,0, with one en_n=1 cycle between grants.
REQ-035 The bench SHALL check wrap: ptr=6 and req=8'h05 -> idx=0, then 2.
REQ-036 The bench SHALL check timeout: req=8'h02 held, done never asserted, HOLD_MAX=16 -> en_n low for 16 cycles, timeout pulse coinciding with en_n returning to 1; then done and the timeout condition in the same cycle -> timeout=0.
REQ-037 The bench SHALL check mid-grant reset: rst=1 during GRANT -> en_n=1, idx=0 next cycle, no timeout pulse.
